// File: rtl/apu_issue_queue_if.sv
// rtl/apu_issue_queue_if.sv - core-side and decoder-side signal bundle for apu_issue_queue
interface apu_issue_queue_if #(
    parameter int DEPTH = 4
);
    logic                     core_req;
    logic                     core_gnt;
    logic [95:0]              core_operands;
    logic [5:0]               core_op;
    logic [14:0]              core_flags;
    logic                     core_rvalid;
    logic [31:0]              core_result;
    logic                     dec_req;
    logic                     dec_gnt;
    logic [95:0]              dec_operands;
    logic [5:0]               dec_op;
    logic [14:0]              dec_flags;
    logic                     dec_rvalid;
    logic [31:0]              dec_result;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [1:0]               outstanding;
    logic                     protocol_err;

    modport slave (
        input  core_req, core_operands, core_op, core_flags,
        input  dec_gnt, dec_rvalid, dec_result,
        output core_gnt, core_rvalid, core_result,
        output dec_req, dec_operands, dec_op, dec_flags,
        output occupancy, outstanding, protocol_err
    );

    modport master (
        output core_req, core_operands, core_op, core_flags,
        output dec_gnt, dec_rvalid, dec_result,
        input  core_gnt, core_rvalid, core_result,
        input  dec_req, dec_operands, dec_op, dec_flags,
        input  occupancy, outstanding, protocol_err
    );
endinterface

// File: rtl/apu_issue_queue.sv
// rtl/apu_issue_queue.sv - in-order APU request FIFO between core and vector decoder
module apu_issue_queue #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 1
) (
    input  logic            clk,
    input  logic            reset,
    apu_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 96 + 6 + 15;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [1:0]    outstanding_q;
    logic          core_rvalid_q;
    logic [31:0]   core_result_q;
    logic          protocol_err_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          done;
    logic          dec_req_w;

    // Extra pointer MSB makes the difference equal DEPTH when full, 0 when empty
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.core_req & ~full;
    assign dec_req_w = ~empty & (outstanding_q < 2'(MAX_OUTSTANDING));
    assign pop       = dec_req_w & bus.dec_gnt;
    assign done      = bus.dec_rvalid & (outstanding_q != 2'd0);

    assign bus.core_gnt     = ~full;
    assign bus.dec_req      = dec_req_w;
    assign {bus.dec_operands, bus.dec_op, bus.dec_flags} = mem[rd_ptr[AW-1:0]];
    assign bus.occupancy    = count;
    assign bus.outstanding  = outstanding_q;
    assign bus.core_rvalid  = core_rvalid_q;
    assign bus.core_result  = core_result_q;
    assign bus.protocol_err = protocol_err_q;

    // Storage carries no reset; stale entries are never visible through dec_req
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.core_operands, bus.core_op, bus.core_flags};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstanding_q  <= 2'd0;
            core_rvalid_q  <= 1'b0;
            core_result_q  <= 32'd0;
            protocol_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            outstanding_q <= outstanding_q + 2'(pop) - 2'(done);
            core_rvalid_q <= bus.dec_rvalid;
            // A spurious completion is still forwarded, only flagged
            if (bus.dec_rvalid) begin
                core_result_q <= bus.dec_result;
            end
            if (bus.dec_rvalid && (outstanding_q == 2'd0)) begin
                protocol_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apu_issue_queue.sv
// tb/tb_apu_issue_queue.sv - randomized self-checking bench for apu_issue_queue
module tb_apu_issue_queue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    apu_issue_queue_if #(.DEPTH(DEPTH)) bus ();

    apu_issue_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [116:0] mq [$];
    int           m_out;
    bit           m_err;
    bit           m_rvalid;
    logic [31:0]  m_result;

    function automatic logic [116:0] rand_entry(input logic [31:0] op0);
        return {$urandom(), $urandom(), op0, 6'($urandom()), 15'($urandom())};
    endfunction

    function automatic bit m_dec_req();
        return (mq.size() != 0) && (m_out < MAX_OUT);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out    = 0;
        m_err    = 0;
        m_rvalid = 0;
        m_result = 32'd0;
    endtask

    task automatic idle();
        bus.core_req      = 1'b0;
        bus.core_operands = '0;
        bus.core_op       = '0;
        bus.core_flags    = '0;
        bus.dec_gnt       = 1'b0;
        bus.dec_rvalid    = 1'b0;
        bus.dec_result    = '0;
    endtask

    task automatic drive_entry(input logic [116:0] e);
        {bus.core_operands, bus.core_op, bus.core_flags} = e;
    endtask

    // Advance model by the rules on the current inputs, then clock the DUT
    task automatic advance();
        bit push, pop, done;
        logic [116:0] tmp;
        push = bus.core_req && (mq.size() != DEPTH);
        pop  = m_dec_req() && bus.dec_gnt;
        done = bus.dec_rvalid && (m_out > 0);
        if (bus.dec_rvalid && m_out == 0) m_err = 1;
        m_rvalid = bus.dec_rvalid;
        if (bus.dec_rvalid) m_result = bus.dec_result;
        if (pop) tmp = mq.pop_front();
        if (push) mq.push_back({bus.core_operands, bus.core_op, bus.core_flags});
        m_out = m_out + int'(pop) - int'(done);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (mq.size() != 0 || m_out != 0); i++) begin
            bus.core_req   = 1'b0;
            bus.dec_gnt    = 1'b1;
            bus.dec_rvalid = (m_out > 0);
            bus.dec_result = $urandom();
            advance();
        end
        idle();
        advance();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #1;
        vectors++; if (bus.occupancy !== 3'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
        vectors++; if (bus.outstanding !== 2'd0) begin miscompares++; $display("FAIL reset_out got %0d want 0", bus.outstanding); end
        vectors++; if (bus.core_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", bus.core_rvalid); end
        vectors++; if (bus.core_result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h want 0", bus.core_result); end
        vectors++; if (bus.protocol_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.protocol_err); end
        vectors++; if (bus.dec_req !== 1'b0) begin miscompares++; $display("FAIL reset_dec_req got %b want 0", bus.dec_req); end
        vectors++; if (bus.core_gnt !== 1'b1) begin miscompares++; $display("FAIL reset_core_gnt got %b want 1", bus.core_gnt); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [116:0] e;
        e = rand_entry($urandom());
        e[116:85] = 32'h0000_0057;
        idle();
        bus.core_req = 1'b1;
        bus.dec_gnt  = 1'b1;
        drive_entry(e);
        vectors++; if (bus.dec_req !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got %b want 0", bus.dec_req); end
        advance();
        bus.core_req = 1'b0;
        vectors++; if (bus.dec_req !== 1'b1) begin miscompares++; $display("FAIL single_dec_req_c1 got %b want 1", bus.dec_req); end
        vectors++; if ({bus.dec_operands, bus.dec_op, bus.dec_flags} !== e) begin miscompares++; $display("FAIL single_head got %h want %h", {bus.dec_operands, bus.dec_op, bus.dec_flags}, e); end
        advance();
        vectors++; if (bus.outstanding !== 2'd1) begin miscompares++; $display("FAIL single_out_c2 got %0d want 1", bus.outstanding); end
        advance();
        bus.dec_rvalid = 1'b1;
        bus.dec_result = 32'h4;
        advance();
        bus.dec_rvalid = 1'b0;
        vectors++; if (bus.core_rvalid !== 1'b1) begin miscompares++; $display("FAIL single_rvalid_c4 got %b want 1", bus.core_rvalid); end
        vectors++; if (bus.core_result !== 32'h4) begin miscompares++; $display("FAIL single_result_c4 got %h want 4", bus.core_result); end
        vectors++; if (bus.outstanding !== 2'd0) begin miscompares++; $display("FAIL single_out_c4 got %0d want 0", bus.outstanding); end
        advance();
        vectors++; if (bus.core_rvalid !== 1'b0) begin miscompares++; $display("FAIL single_pulse got %b want 0", bus.core_rvalid); end
        vectors++; if (bus.core_result !== 32'h4) begin miscompares++; $display("FAIL single_hold got %h want 4", bus.core_result); end
    endtask

    task automatic test_fill();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            bus.core_req = 1'b1;
            drive_entry(rand_entry(32'(i)));
            advance();
            vectors++; if (int'(bus.occupancy) != mq.size()) begin miscompares++; $display("FAIL fill_occ got %0d want %0d", bus.occupancy, mq.size()); end
        end
        vectors++; if (bus.core_gnt !== 1'b0) begin miscompares++; $display("FAIL fill_gnt got %b want 0", bus.core_gnt); end
        drive_entry(rand_entry(32'hdead));
        advance();
        vectors++; if (bus.occupancy !== 3'd4) begin miscompares++; $display("FAIL fill_fifth got %0d want 4", bus.occupancy); end
        bus.dec_gnt = 1'b1;
        vectors++; if (bus.core_gnt !== 1'b0) begin miscompares++; $display("FAIL fill_gnt_on_pop got %b want 0", bus.core_gnt); end
        advance();
        bus.core_req = 1'b0;
        bus.dec_gnt  = 1'b0;
        vectors++; if (bus.occupancy !== 3'd3) begin miscompares++; $display("FAIL fill_after_pop got %0d want 3", bus.occupancy); end
        vectors++; if (bus.core_gnt !== 1'b1) begin miscompares++; $display("FAIL fill_gnt_after got %b want 1", bus.core_gnt); end
        drain();
    endtask

    task automatic test_blocking();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.core_req = 1'b1;
            drive_entry(rand_entry($urandom()));
            advance();
        end
        bus.core_req = 1'b0;
        bus.dec_gnt  = 1'b1;
        advance();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.dec_req !== 1'b0) begin miscompares++; $display("FAIL block_dec_req cyc %0d got %b want 0", i, bus.dec_req); end
            vectors++; if (bus.outstanding !== 2'd1) begin miscompares++; $display("FAIL block_out cyc %0d got %0d want 1", i, bus.outstanding); end
            advance();
        end
        bus.dec_rvalid = 1'b1;
        bus.dec_result = $urandom();
        vectors++; if (bus.dec_req !== 1'b0) begin miscompares++; $display("FAIL block_dec_req_rv got %b want 0", bus.dec_req); end
        advance();
        bus.dec_rvalid = 1'b0;
        bus.dec_gnt    = 1'b0;
        vectors++; if (bus.dec_req !== 1'b1) begin miscompares++; $display("FAIL block_reassert got %b want 1", bus.dec_req); end
        vectors++; if (bus.occupancy !== 3'd2) begin miscompares++; $display("FAIL block_occ got %0d want 2", bus.occupancy); end
        drain();
    endtask

    task automatic test_order_wrap();
        int next_push = 0;
        int next_pop  = 0;
        idle();
        for (int cyc = 0; cyc < 400 && next_pop < 10; cyc++) begin
            bus.core_req = (next_push < 10) && ($urandom_range(0, 3) != 0);
            drive_entry(rand_entry(32'(next_push)));
            bus.dec_gnt    = $urandom_range(0, 1);
            bus.dec_rvalid = (m_out > 0) && ($urandom_range(0, 1) == 1);
            bus.dec_result = $urandom();
            vectors++; if (bus.dec_req !== m_dec_req()) begin miscompares++; $display("FAIL order_dec_req cyc %0d got %b want %b", cyc, bus.dec_req, m_dec_req()); end
            vectors++; if (int'(bus.occupancy) != mq.size()) begin miscompares++; $display("FAIL order_occ cyc %0d got %0d want %0d", cyc, bus.occupancy, mq.size()); end
            vectors++; if (bus.core_rvalid !== m_rvalid || bus.core_result !== m_result) begin miscompares++; $display("FAIL order_result cyc %0d got %b/%h want %b/%h", cyc, bus.core_rvalid, bus.core_result, m_rvalid, m_result); end
            if (m_dec_req() && bus.dec_gnt) begin
                vectors++; if (bus.dec_operands[31:0] !== 32'(next_pop) || {bus.dec_operands, bus.dec_op, bus.dec_flags} !== mq[0]) begin miscompares++; $display("FAIL order_seq got %0d want %0d", bus.dec_operands[31:0], next_pop); end
                next_pop++;
            end
            if (bus.core_req && mq.size() != DEPTH) next_push++;
            advance();
        end
        vectors++; if (next_pop != 10) begin miscompares++; $display("FAIL order_count got %0d want 10", next_pop); end
        drain();
    endtask

    task automatic test_push_pop();
        logic [116:0] second;
        idle();
        for (int i = 0; i < 2; i++) begin
            bus.core_req = 1'b1;
            drive_entry(rand_entry($urandom()));
            advance();
        end
        second = mq[1];
        drive_entry(rand_entry($urandom()));
        bus.dec_gnt = 1'b1;
        advance();
        idle();
        vectors++; if (bus.occupancy !== 3'd2) begin miscompares++; $display("FAIL pushpop_occ got %0d want 2", bus.occupancy); end
        vectors++; if ({bus.dec_operands, bus.dec_op, bus.dec_flags} !== second) begin miscompares++; $display("FAIL pushpop_head got %h want %h", {bus.dec_operands, bus.dec_op, bus.dec_flags}, second); end
        drain();
    endtask

    task automatic test_spurious_reset();
        logic [31:0] r;
        idle();
        r = $urandom();
        bus.dec_rvalid = 1'b1;
        bus.dec_result = r;
        advance();
        bus.dec_rvalid = 1'b0;
        vectors++; if (bus.protocol_err !== 1'b1) begin miscompares++; $display("FAIL spur_err got %b want 1", bus.protocol_err); end
        vectors++; if (bus.core_rvalid !== 1'b1 || bus.core_result !== r) begin miscompares++; $display("FAIL spur_fwd got %b/%h want 1/%h", bus.core_rvalid, bus.core_result, r); end
        vectors++; if (bus.outstanding !== 2'd0) begin miscompares++; $display("FAIL spur_out got %0d want 0", bus.outstanding); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.core_req = 1'b1;
            drive_entry(rand_entry($urandom()));
            advance();
        end
        bus.core_req = 1'b0;
        bus.dec_gnt  = 1'b1;
        advance();
        bus.dec_gnt  = 1'b0;
        vectors++; if (bus.protocol_err !== 1'b1) begin miscompares++; $display("FAIL spur_sticky got %b want 1", bus.protocol_err); end
        vectors++; if (bus.occupancy !== 3'd3 || bus.outstanding !== 2'd1) begin miscompares++; $display("FAIL spur_prereset got %0d/%0d want 3/1", bus.occupancy, bus.outstanding); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (bus.occupancy !== 3'd0) begin miscompares++; $display("FAIL rst_occ got %0d want 0", bus.occupancy); end
        vectors++; if (bus.outstanding !== 2'd0) begin miscompares++; $display("FAIL rst_out got %0d want 0", bus.outstanding); end
        vectors++; if (bus.protocol_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", bus.protocol_err); end
        vectors++; if (bus.core_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %b want 0", bus.core_rvalid); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        vectors++; if (bus.dec_req !== 1'b0 || bus.occupancy !== 3'd0) begin miscompares++; $display("FAIL rst_empty got %b/%0d want 0/0", bus.dec_req, bus.occupancy); end
        advance();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_fill();
        test_blocking();
        test_order_wrap();
        test_push_pop();
        test_spurious_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apu_issue_queue.md
Name: apu_issue_queue

Overview:
- In-order request buffer between the core's APU port and vector_decoder.
- Accepts APU requests while the decoder is busy executing a multi-cycle vector instruction, stores them in a FIFO and issues them one at a time when the decoder grants.
- Tracks outstanding instructions and returns decoder results to the core through a registered path.
- Keeps the core's APU grant independent of decoder state.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- MAX_OUTSTANDING, 1, maximum number of instructions issued to the decoder and not yet completed; range 1–3.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- core_req  input  1  core APU request.
- core_gnt  output  1  queue can accept a request this cycle.
- core_operands  input  96  {operand2 (instruction), operand1, operand0}; operand0 in [31:0].
- core_op  input  6  APU op.
- core_flags  input  15  APU flags.
- core_rvalid  output  1  result valid to core, one-cycle pulse.
- core_result  output  32  result to core.
- dec_req  output  1  entry at FIFO head presented to decoder.
- dec_gnt  input  1  decoder accepts the head entry.
- dec_operands  output  96  head entry operands.
- dec_op  output  6  head entry op.
- dec_flags  output  15  head entry flags.
- dec_rvalid  input  1  decoder completion pulse.
- dec_result  input  32  decoder result.
- occupancy  output  $clog2(DEPTH)+1  number of valid FIFO entries.
- outstanding  output  2  number of issued, uncompleted instructions.
- protocol_err  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Read/write pointers, occupancy, outstanding, core_rvalid, core_result and protocol_err all cleared to 0.
  - FIFO contents are don't-care.
  - Assertion mid-operation drops all queued and in-flight instructions.
  - The first cycle after release behaves as empty.
- Push:
  - core_gnt = (occupancy != DEPTH); combinational, independent of core_req.
  - Push when core_req & core_gnt: write {operands, op, flags} at the write pointer.
  - Pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
- Issue:
  - dec_req = (occupancy != 0) & (outstanding < MAX_OUTSTANDING).
  - dec_operands/op/flags always show the head entry; don't-care when empty.
  - Pop when dec_req & dec_gnt; outstanding increments.
  - A pushed entry reaches dec_req no earlier than the cycle after the push; there is no bypass. Minimum latency core accept → dec_req is 1 cycle.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance. Allowed when neither full nor empty.
  - When full, core_gnt = 0 even if a pop happens that cycle.
  - Issue and dec_rvalid in the same cycle: outstanding unchanged.
- Completion:
  - dec_rvalid with outstanding > 0: outstanding decrements.
  - Next cycle: core_rvalid = 1 and core_result = dec_result, registered. Latency is exactly 1 cycle.
  - core_result holds its value until the next completion.
- Errors:
  - dec_rvalid while outstanding == 0: protocol_err set (sticky until reset), outstanding stays 0, and the result is still forwarded to the core.
  - dec_gnt without dec_req: ignored.
- Ordering: strict FIFO order; results returned in issue order.

Test Plan:
- Single request, decoder grants immediately:
  - Stimulus: push with operand2=0x0000_0057 at cycle 0; dec_gnt tied high; dec_rvalid with dec_result=0x4 at cycle 3.
  - Required: dec_req at cycle 1; outstanding=1 at cycle 2; core_rvalid with core_result=0x4 at cycle 4.
- Fill to full:
  - Stimulus: hold dec_gnt=0 and push 4 requests (DEPTH=4).
  - Required: occupancy=4, core_gnt=0; a 5th core_req is not accepted; after one pop, core_gnt=1 the following cycle.
- MAX_OUTSTANDING=1 blocking:
  - Stimulus: issue one entry with 2 queued behind it; dec_gnt high; withhold dec_rvalid for 5 cycles.
  - Required: dec_req=0 throughout, outstanding=1; dec_req reasserts the cycle after dec_rvalid.
- Order and wrap-around:
  - Stimulus: push 10 entries with operand0=0..9 through a DEPTH=4 queue with random dec_gnt.
  - Required: decoder sees operand0 in order 0..9; pointers wrap with no loss or duplication.
- Simultaneous push/pop at occupancy=2:
  - Required: occupancy stays 2; head advances to the next entry.
- Spurious completion, then reset:
  - Stimulus: dec_rvalid with outstanding=0; later assert reset mid-queue with occupancy=3.
  - Required: protocol_err=1 and remains set; on reset, occupancy=0, outstanding=0, protocol_err=0 and core_rvalid=0 immediately.
